// File: rtl/input_layer_streamer.sv
// input_layer_streamer: fetches KxK windows per layer from a read port and deals layers round-robin to NUM_CH FIFO-backed streams.
// Define STREAM_LAST_EN to add the per-channel ch_last flag marking each layer's final window.
module input_layer_streamer #(
  parameter int ADDR_W     = 32,
  parameter int PIX_W      = 8,
  parameter int K          = 3,
  parameter int NUM_CH     = 4,
  parameter int ID_W       = 10,
  parameter int WIN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            cfg_base_addr,
  input  logic [ADDR_W-1:0]            cfg_layer_stride,
  input  logic [ID_W-1:0]              cfg_num_layers,
  input  logic [WIN_W-1:0]             cfg_win_per_layer,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_req,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic                         rd_gnt,
  input  logic                         rd_valid,
  input  logic [K*K*PIX_W-1:0]         rd_data,
  output logic [NUM_CH*K*K*PIX_W-1:0]  ch_data,
  output logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_rdy,
  output logic [NUM_CH*ID_W-1:0]       ch_id
`ifdef STREAM_LAST_EN
  ,output logic [NUM_CH-1:0]           ch_last
`endif
);
  localparam int DATA_W = K*K*PIX_W;
  localparam int WORD_BYTES = (DATA_W+7)/8;
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef STREAM_LAST_EN
  localparam int E_W = DATA_W+ID_W+1;
`else
  localparam int E_W = DATA_W+ID_W;
`endif
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_e;
  state_e state_q, state_d;
  logic [ID_W-1:0] num_q, num_d, lay_q, lay_d;
  logic [WIN_W-1:0] win_q, win_d, w_q, w_d;
  logic [ADDR_W-1:0] stride_q, stride_d, lbase_q, lbase_d, off_q, off_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [NUM_CH-1:0] full, push;
  logic last_w;
  logic [E_W-1:0] wr_word;
  assign last_w = w_q == win_q - 1'b1;
`ifdef STREAM_LAST_EN
  assign wr_word = {last_w, rd_data, lay_q};
`else
  assign wr_word = {rd_data, lay_q};
`endif
  assign rd_addr = lbase_q + off_q;
  assign rd_req = state_q == REQ && !full[ch_q];
  assign busy = state_q == REQ || state_q == WAIT;
  assign done = state_q == FIN;
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    win_d = win_q;
    stride_d = stride_q;
    lbase_d = lbase_q;
    off_d = off_q;
    lay_d = lay_q;
    w_d = w_q;
    ch_d = ch_q;
    push = '0;
    case (state_q)
      IDLE: if (start) begin
        num_d = cfg_num_layers;
        win_d = cfg_win_per_layer;
        stride_d = cfg_layer_stride;
        lbase_d = cfg_base_addr;
        off_d = '0;
        lay_d = '0;
        w_d = '0;
        ch_d = '0;
        state_d = (cfg_num_layers == '0 || cfg_win_per_layer == '0) ? FIN : REQ;
      end
      REQ: state_d = (rd_req && rd_gnt) ? WAIT : REQ;
      WAIT: if (rd_valid) begin
        push[ch_q] = 1'b1;
        w_d = last_w ? '0 : w_q + 1'b1;
        off_d = last_w ? '0 : off_q + ADDR_W'(WORD_BYTES);
        lay_d = last_w ? lay_q + 1'b1 : lay_q;
        lbase_d = last_w ? lbase_q + stride_q : lbase_q;
        ch_d = !last_w ? ch_q : (ch_q == CH_W'(NUM_CH-1)) ? '0 : ch_q + 1'b1;
        state_d = (last_w && lay_q == num_q - 1'b1) ? FIN : REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q <= '0;
      win_q <= '0;
      stride_q <= '0;
      lbase_q <= '0;
      off_q <= '0;
      lay_q <= '0;
      w_q <= '0;
      ch_q <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      win_q <= win_d;
      stride_q <= stride_d;
      lbase_q <= lbase_d;
      off_q <= off_d;
      lay_q <= lay_d;
      w_q <= w_d;
      ch_q <= ch_d;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [E_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0] cnt_q;
    logic pop;
    assign pop = ch_valid[c] && ch_rdy[c];
    assign full[c] = cnt_q == (PTR_W+1)'(FIFO_DEPTH);
    assign ch_valid[c] = cnt_q != '0;
    // Head is zeroed while empty so idle outputs read as 0.
`ifdef STREAM_LAST_EN
    assign {ch_last[c], ch_data[c*DATA_W +: DATA_W], ch_id[c*ID_W +: ID_W]} = ch_valid[c] ? mem_q[rd_q] : '0;
`else
    assign {ch_data[c*DATA_W +: DATA_W], ch_id[c*ID_W +: ID_W]} = ch_valid[c] ? mem_q[rd_q] : '0;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q <= '0;
        rd_q <= '0;
        cnt_q <= '0;
      end else begin
        if (push[c]) begin
          mem_q[wr_q] <= wr_word;
          wr_q <= wr_q + 1'b1;
        end
        if (pop) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + (PTR_W+1)'(push[c]) - (PTR_W+1)'(pop);
      end
    end
  end
endmodule
